mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, memory address width; DATA_W, 16, memory data width; SCRUB_GAP, 8, consecutive request-free IDLE cycles before a background scrub read (min 1).
REQ-002 Ports SHALL be (name direction width meaning): sck in 1 main clock, all logic on rising edge; rst in 1 synchronous active-high reset.
REQ-003 req_i in 2, per-requester read request (level, held until granted); addr_i in 2*ADDR_W, requester k address at [k*ADDR_W +: ADDR_W].
REQ-004 gnt_o out 2, one-hot grant pulse; rvalid_o out 2, one-hot read-data-valid pulse; rdata_o out DATA_W, read data; rerr_o out 1, alarm status of returned data, valid with rvalid_o.
REQ-005 scrub_en_i in 1, enables background scrubbing; err_clr_i in 1, clears sticky error; err_flag_o out 1, sticky alarm flag; err_addr_o out ADDR_W, address of first alarm since last clear.
REQ-006 addr_mem_o out ADDR_W, memory address; en_mem_o out 1, memory read enable; data_mem_i in DATA_W, memory data, valid the cycle after en_mem_o; alarm_sig_i in 1, memory alarm, active-low, valid with data_mem_i.

Function
REQ-007 The FSM SHALL have states IDLE, ISSUE, CAPTURE; transitions: IDLE->ISSUE when an access is selected, ISSUE->CAPTURE unconditionally, CAPTURE->IDLE unconditionally.
REQ-008 In IDLE, selection SHALL be registered at the clock edge: requester address and source (req0, req1, scrub) latched, state moves to ISSUE.
REQ-009 In ISSUE, en_mem_o SHALL be 1 and addr_mem_o SHALL equal the latched address; gnt_o[k] SHALL be 1 for exactly this cycle when the source is requester k; scrub accesses assert no gnt_o.
REQ-010 In CAPTURE, data_mem_i and ~alarm_sig_i SHALL be registered; the following cycle rvalid_o[k] SHALL pulse for one cycle with rdata_o and rerr_o (requester sources only).
REQ-011 Latency: req_i asserted in IDLE at cycle T -> gnt_o cycle T+1 -> rvalid_o cycle T+3; maximum throughput one access per 3 cycles.
REQ-012 Outside ISSUE, en_mem_o SHALL be 0 and addr_mem_o SHALL be 0.
REQ-013 rdata_o and rerr_o SHALL hold their last values between rvalid_o pulses.
REQ-014 Arbitration SHALL be round-robin: with both req_i set, grant the requester not granted last; a single requester is granted immediately; pointer updates only on requester grants.
REQ-015 A requester SHALL deassert req_i the cycle after its gnt_o unless requesting again; a req_i held continuously is treated as back-to-back requests.
REQ-016 Gap counter SHALL count IDLE cycles with req_i==0 and scrub_en_i==1, saturating at SCRUB_GAP; it SHALL clear on any selection and hold at 0 while scrub_en_i==0.
REQ-017 A scrub SHALL be selected in IDLE when req_i==0, scrub_en_i==1 and gap counter==SCRUB_GAP; any req_i in the same cycle SHALL win over the scrub.
REQ-018 Scrub address SHALL increment after each scrub CAPTURE, wrapping 2^ADDR_W-1 -> 0; it SHALL hold while scrub_en_i==0.
REQ-019 Any access (requester or scrub) capturing alarm_sig_i==0 SHALL set err_flag_o; err_addr_o SHALL capture its address only if err_flag_o was 0.
REQ-020 err_clr_i SHALL clear err_flag_o and err_addr_o; a simultaneous alarm capture SHALL win (flag set, new address captured).
REQ-021 scrub_en_i deasserted during a scrub ISSUE/CAPTURE SHALL not abort it; the access completes and the address increments.

Reset
REQ-022 On rst==1 at a clock edge: state IDLE, all outputs 0, rdata_o 0, scrub address 0, gap counter 0, round-robin pointer favouring requester 0.
REQ-023 rst during ISSUE or CAPTURE SHALL abort the access with no rvalid_o and no err_flag_o update.

Structure
REQ-024 Package mem_arb_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and source encoding (SRC_REQ0, SRC_REQ1, SRC_SCRUB).
REQ-025 Two-way round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], advance, gnt one-hot, sync reset).

Verification
REQ-026 req_i=01, addr 5'h0A, memory returns 16'hBEEF, alarm_sig_i=1 -> gnt_o=01 at T+1, en_mem_o=1 addr 0A at T+1, rvalid_o=01 rdata_o=BEEF rerr_o=0 at T+3.
REQ-027 req_i=11 held continuously -> grants alternate 01,10,01,10 every 3 cycles starting with 01 after reset.
REQ-028 scrub_en_i=1, no requests, SCRUB_GAP=8 -> first en_mem_o addr 00 after 8 idle cycles, then 01, 02..., 1F wraps to 00; no gnt_o/rvalid_o.
REQ-029 Scrub at address 07 with alarm_sig_i=0, later alarm at 0C -> err_flag_o=1, err_addr_o=07; err_clr_i with simultaneous alarm at 03 -> err_flag_o=1, err_addr_o=03.
REQ-030 rst asserted during ISSUE of requester 1 -> no rvalid_o, all outputs 0 next cycle, next req_i=11 grants requester 0 first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory read arbiter.
//   state_t : arbiter FSM states (IDLE -> ISSUE -> CAPTURE -> IDLE)
//   src_t   : source of the access in flight (requester 0, requester 1, scrubber)
//   src_onehot() : maps a requester source to its one-hot grant/rvalid bit
package mem_arb_pkg;

   localparam int DEF_ADDR_W    = 5;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_SCRUB_GAP = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SRC_REQ0  = 2'd0,
      SRC_REQ1  = 2'd1,
      SRC_SCRUB = 2'd2
   } src_t;

   // Scrub accesses have no requester, so they map to no strobe bit.
   function automatic logic [1:0] src_onehot(input src_t src);
      logic [1:0] oh;
      oh = 2'b00;
      if (src == SRC_REQ0) oh = 2'b01;
      if (src == SRC_REQ1) oh = 2'b10;
      return oh;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector.
//   clk     : clock, rising edge
//   srst    : synchronous active-high reset (favours requester 0)
//   req     : request vector [1:0]
//   advance : the current gnt is being taken; rotate priority
//   gnt     : one-hot combinational selection (0 when no request)
module rr_arb2 (
   input  logic       clk,
   input  logic       srst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // Requester that wins when both are asserting.
   logic prio_reg;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio_reg ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Whoever was just served loses the next tie.
   always_ff @(posedge clk) begin
      if (srst) begin
         prio_reg <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         prio_reg <= gnt[0];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory read arbiter with background scrubbing and a sticky
// alarm log. Each access is IDLE (select) -> ISSUE (en_mem_o) -> CAPTURE
// (memory data valid) and the result is returned the cycle after CAPTURE.
//   sck, rst              : clock and synchronous active-high reset
//   req_i, addr_i         : per-requester level requests and packed addresses
//   gnt_o, rvalid_o       : one-hot grant and read-valid pulses
//   rdata_o, rerr_o       : returned data and its alarm status (held)
//   scrub_en_i            : enables scrub reads after SCRUB_GAP idle cycles
//   err_clr_i             : clears err_flag_o / err_addr_o
//   err_flag_o,err_addr_o : sticky alarm flag and first failing address
//   addr_mem_o, en_mem_o  : memory read port (address is 0 when not enabled)
//   data_mem_i,alarm_sig_i: memory data and active-low alarm, cycle after en
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SCRUB_GAP = DEF_SCRUB_GAP
) (
   input  logic                sck,
   input  logic                rst,
   input  logic [1:0]          req_i,
   input  logic [2*ADDR_W-1:0] addr_i,
   output logic [1:0]          gnt_o,
   output logic [1:0]          rvalid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                rerr_o,
   input  logic                scrub_en_i,
   input  logic                err_clr_i,
   output logic                err_flag_o,
   output logic [ADDR_W-1:0]   err_addr_o,
   output logic [ADDR_W-1:0]   addr_mem_o,
   output logic                en_mem_o,
   input  logic [DATA_W-1:0]   data_mem_i,
   input  logic                alarm_sig_i
);

   localparam int GAP_W = $clog2(SCRUB_GAP + 1);

   state_t              state_reg;
   src_t                src_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [1:0]          gnt_reg;
   logic [1:0]          rvalid_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic                rerr_reg;
   logic                en_mem_reg;
   logic [ADDR_W-1:0]   addr_mem_reg;
   logic                err_flag_reg;
   logic [ADDR_W-1:0]   err_addr_reg;
   logic [ADDR_W-1:0]   scrub_addr_reg;
   logic [GAP_W-1:0]    gap_reg;

   logic [ADDR_W-1:0]   req_addr [2];
   logic [1:0]          arb_gnt;
   logic                sel_req;
   logic                sel_scrub;
   logic [ADDR_W-1:0]   sel_addr;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_addr_unpack
         assign req_addr[gi] = addr_i[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   rr_arb2 u_rr_arb2 (
      .clk     (sck),
      .srst    (rst),
      .req     (req_i),
      .advance (sel_req),
      .gnt     (arb_gnt)
   );

   // Requests always beat a due scrub in the same IDLE cycle.
   assign sel_req   = (state_reg == IDLE) && (req_i != 2'b00);
   assign sel_scrub = (state_reg == IDLE) && (req_i == 2'b00) && scrub_en_i &&
                      (gap_reg == GAP_W'(SCRUB_GAP));

   always_comb begin
      sel_addr = scrub_addr_reg;
      if (sel_req) sel_addr = arb_gnt[0] ? req_addr[0] : req_addr[1];
   end

   always_ff @(posedge sck) begin
      if (rst) begin
         state_reg      <= IDLE;
         src_reg        <= SRC_REQ0;
         addr_reg       <= '0;
         gnt_reg        <= '0;
         rvalid_reg     <= '0;
         rdata_reg      <= '0;
         rerr_reg       <= 1'b0;
         en_mem_reg     <= 1'b0;
         addr_mem_reg   <= '0;
         err_flag_reg   <= 1'b0;
         err_addr_reg   <= '0;
         scrub_addr_reg <= '0;
         gap_reg        <= '0;
      end else begin
         // Strobes and the memory port are single-cycle by default.
         gnt_reg      <= '0;
         rvalid_reg   <= '0;
         en_mem_reg   <= 1'b0;
         addr_mem_reg <= '0;

         if (!scrub_en_i) begin
            gap_reg <= '0;
         end else if (state_reg == IDLE) begin
            if (sel_req || sel_scrub)                 gap_reg <= '0;
            else if (gap_reg != GAP_W'(SCRUB_GAP))    gap_reg <= gap_reg + GAP_W'(1);
         end

         // A clear is overridden below by an alarm captured on the same edge.
         if (err_clr_i) begin
            err_flag_reg <= 1'b0;
            err_addr_reg <= '0;
         end

         case (state_reg)
            IDLE: begin
               if (sel_req || sel_scrub) begin
                  src_reg      <= sel_req ? (arb_gnt[0] ? SRC_REQ0 : SRC_REQ1) : SRC_SCRUB;
                  addr_reg     <= sel_addr;
                  gnt_reg      <= sel_req ? arb_gnt : 2'b00;
                  en_mem_reg   <= 1'b1;
                  addr_mem_reg <= sel_addr;
                  state_reg    <= ISSUE;
               end
            end
            ISSUE: begin
               state_reg <= CAPTURE;
            end
            CAPTURE: begin
               state_reg <= IDLE;
               if (src_reg == SRC_SCRUB) begin
                  scrub_addr_reg <= scrub_addr_reg + ADDR_W'(1);
               end else begin
                  rvalid_reg <= src_onehot(src_reg);
                  rdata_reg  <= data_mem_i;
                  rerr_reg   <= ~alarm_sig_i;
               end
               if (!alarm_sig_i) begin
                  err_flag_reg <= 1'b1;
                  if (!err_flag_reg || err_clr_i) err_addr_reg <= addr_reg;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign gnt_o      = gnt_reg;
   assign rvalid_o   = rvalid_reg;
   assign rdata_o    = rdata_reg;
   assign rerr_o     = rerr_reg;
   assign en_mem_o   = en_mem_reg;
   assign addr_mem_o = addr_mem_reg;
   assign err_flag_o = err_flag_reg;
   assign err_addr_o = err_addr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter. A transaction-level model
// schedules the expected strobes of every access by cycle number and keeps
// the expected held/sticky outputs; a small memory model answers reads.
module tb_mem_arbiter;

   localparam int AW  = 5;
   localparam int DW  = 16;
   localparam int GAP = 8;

   logic          sck = 1'b0;
   logic          rst;
   logic [1:0]    req_i;
   logic [2*AW-1:0] addr_i;
   logic [1:0]    gnt_o;
   logic [1:0]    rvalid_o;
   logic [DW-1:0] rdata_o;
   logic          rerr_o;
   logic          scrub_en_i;
   logic          err_clr_i;
   logic          err_flag_o;
   logic [AW-1:0] err_addr_o;
   logic [AW-1:0] addr_mem_o;
   logic          en_mem_o;
   logic [DW-1:0] data_mem_i;
   logic          alarm_sig_i;

   always #5 sck = ~sck;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SCRUB_GAP(GAP)) dut (
      .sck         (sck),
      .rst         (rst),
      .req_i       (req_i),
      .addr_i      (addr_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .rerr_o      (rerr_o),
      .scrub_en_i  (scrub_en_i),
      .err_clr_i   (err_clr_i),
      .err_flag_o  (err_flag_o),
      .err_addr_o  (err_addr_o),
      .addr_mem_o  (addr_mem_o),
      .en_mem_o    (en_mem_o),
      .data_mem_i  (data_mem_i),
      .alarm_sig_i (alarm_sig_i)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_txn    = 0;

   // Memory contents and per-address alarm level (1 = healthy).
   logic [DW-1:0] mem [32];
   logic          alarm_mem [32];
   logic          prev_en;
   logic [AW-1:0] prev_addr;

   // Expected strobes, scheduled by cycle number modulo 4.
   logic [1:0]    e_gnt  [4];
   logic [1:0]    e_rv   [4];
   logic          e_en   [4];
   logic [AW-1:0] e_addr [4];
   // Expected held/sticky outputs for the current cycle.
   logic [DW-1:0] m_rdata;
   logic          m_rerr;
   logic          m_flag;
   logic [AW-1:0] m_eaddr;
   // Model bookkeeping.
   int            free_at;
   int            gap;
   int            scrub_a;
   int            last;
   bit            pend;
   int            pend_due;
   int            pend_src;
   logic [AW-1:0] pend_addr;
   logic [DW-1:0] pend_data;
   logic          pend_rerr;
   bit            cmp_on;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: check outputs, answer memory, drive inputs, advance model.
   task automatic step(input bit r, input logic [1:0] rq, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input bit se, input bit clr);
      int s;
      int n;
      int sel;
      logic [AW-1:0] a;
      @(negedge sck);
      s = cyc % 4;
      if (cmp_on) begin
         check_value("gnt_o",      32'(gnt_o),      32'(e_gnt[s]));
         check_value("rvalid_o",   32'(rvalid_o),   32'(e_rv[s]));
         check_value("en_mem_o",   32'(en_mem_o),   32'(e_en[s]));
         check_value("addr_mem_o", 32'(addr_mem_o), 32'(e_addr[s]));
         check_value("rdata_o",    32'(rdata_o),    32'(m_rdata));
         check_value("rerr_o",     32'(rerr_o),     32'(m_rerr));
         check_value("err_flag_o", 32'(err_flag_o), 32'(m_flag));
         check_value("err_addr_o", 32'(err_addr_o), 32'(m_eaddr));
      end
      e_gnt[s] = '0; e_rv[s] = '0; e_en[s] = 1'b0; e_addr[s] = '0;

      // Memory answers the cycle after an enable; otherwise it drives junk.
      data_mem_i  = prev_en ? mem[prev_addr] : DW'($urandom);
      alarm_sig_i = prev_en ? alarm_mem[prev_addr] : 1'($urandom);
      prev_en     = en_mem_o;
      prev_addr   = addr_mem_o;

      rst        = r;
      req_i      = rq;
      addr_i     = {a1, a0};
      scrub_en_i = se;
      err_clr_i  = clr;

      if (r) begin
         for (int i = 0; i < 4; i++) begin
            e_gnt[i] = '0; e_rv[i] = '0; e_en[i] = 1'b0; e_addr[i] = '0;
         end
         m_rdata = '0; m_rerr = 1'b0; m_flag = 1'b0; m_eaddr = '0;
         pend = 1'b0; free_at = cyc + 1; gap = 0; scrub_a = 0; last = 1;
      end else begin
         n = (cyc + 1) % 4;
         if (pend && pend_due == cyc + 1) begin
            if (pend_src < 2) begin
               e_rv[n] = 2'(1 << pend_src);
               m_rdata = pend_data;
               m_rerr  = pend_rerr;
            end else begin
               scrub_a = (scrub_a + 1) % 32;
            end
            if (pend_rerr) begin
               if (!m_flag || clr) m_eaddr = pend_addr;
               m_flag = 1'b1;
            end else if (clr) begin
               m_flag = 1'b0; m_eaddr = '0;
            end
            n_txn++;
            $display("txn %0d: src=%0d addr=%02h data=%04h rerr=%0d", n_txn, pend_src, pend_addr, pend_data, pend_rerr);
            pend = 1'b0;
         end else if (clr) begin
            m_flag = 1'b0; m_eaddr = '0;
         end

         if (cyc >= free_at) begin
            sel = -1;
            if (rq == 2'b11)            sel = (last == 0) ? 1 : 0;
            else if (rq == 2'b01)       sel = 0;
            else if (rq == 2'b10)       sel = 1;
            else if (se && gap == GAP)  sel = 2;
            if (sel >= 0) begin
               if (sel < 2) last = sel;
               a = (sel == 0) ? a0 : (sel == 1) ? a1 : AW'(scrub_a);
               e_gnt[n]  = (sel < 2) ? 2'(1 << sel) : 2'b00;
               e_en[n]   = 1'b1;
               e_addr[n] = a;
               pend = 1'b1; pend_due = cyc + 3; pend_src = sel;
               pend_addr = a; pend_data = mem[a]; pend_rerr = !alarm_mem[a];
               free_at = cyc + 3;
               gap = 0;
            end else if (!se) begin
               gap = 0;
            end else if (gap < GAP) begin
               gap++;
            end
         end else if (!se) begin
            gap = 0;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int cycles, input bit se);
      for (int i = 0; i < cycles; i++) step(1'b0, 2'b00, AW'($urandom), AW'($urandom), se, 1'b0);
   endtask

   initial begin
      int mode;
      bit se_r;
      bit r_r;
      bit clr_r;
      logic [1:0] rq_r;

      rst = 1'b1; req_i = '0; addr_i = '0; scrub_en_i = 1'b0; err_clr_i = 1'b0;
      data_mem_i = '0; alarm_sig_i = 1'b1; prev_en = 1'b0; prev_addr = '0;
      for (int i = 0; i < 32; i++) begin
         mem[i] = DW'($urandom);
         alarm_mem[i] = 1'b1;
      end
      cmp_on = 1'b0;
      step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
      cmp_on = 1'b1;
      step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);

      // Single requester 0 read of 0x0A.
      mem[10] = 16'hBEEF;
      step(1'b0, 2'b01, 5'h0A, 5'h00, 1'b0, 1'b0);
      idle(4, 1'b0);
      check_value("beef_rdata", 32'(rdata_o), 32'h0000BEEF);
      check_value("beef_rerr",  32'(rerr_o),  32'h0);

      // Both requesting continuously after reset: alternate starting with 0.
      step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 2'b11, 5'h11, 5'h12, 1'b0, 1'b0);
      idle(4, 1'b0);

      // Scrub sweep over the whole space with alarms at 0x07 and 0x0C.
      step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
      alarm_mem[7]  = 1'b0;
      alarm_mem[12] = 1'b0;
      idle(410, 1'b1);
      check_value("scrub_flag", 32'(err_flag_o), 32'h1);
      check_value("scrub_eadr", 32'(err_addr_o), 32'h7);
      idle(4, 1'b0);

      // Clear coinciding with an alarm capture at 0x03.
      alarm_mem[3] = 1'b0;
      step(1'b0, 2'b01, 5'h03, 5'h00, 1'b0, 1'b0);
      step(1'b0, 2'b00, 5'h00, 5'h00, 1'b0, 1'b0);
      step(1'b0, 2'b00, 5'h00, 5'h00, 1'b0, 1'b1);
      idle(3, 1'b0);
      check_value("clr_flag", 32'(err_flag_o), 32'h1);
      check_value("clr_eadr", 32'(err_addr_o), 32'h3);

      // Reset during requester 1's ISSUE, then a tie goes to requester 0.
      step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
      step(1'b0, 2'b10, 5'h00, 5'h05, 1'b0, 1'b0);
      step(1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
      idle(4, 1'b0);
      step(1'b0, 2'b11, 5'h08, 5'h09, 1'b0, 1'b0);
      idle(4, 1'b0);

      // Randomised traffic with scrubbing, clears and occasional resets.
      for (int i = 0; i < 32; i++) begin
         mem[i] = DW'($urandom);
         alarm_mem[i] = ($urandom_range(0, 4) != 0);
      end
      mode = 0;
      se_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) mode = 1 - mode;
         if ($urandom_range(0, 99) == 0) se_r = ~se_r;
         if (mode == 0) rq_r = 2'($urandom_range(0, 3));
         else           rq_r = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         clr_r = ($urandom_range(0, 24) == 0);
         r_r   = ($urandom_range(0, 199) == 0);
         step(r_r, rq_r, AW'($urandom), AW'($urandom), se_r, clr_r);
      end
      idle(4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
